// File: rtl/spi_status_tx.sv
// spi_status_tx
//   Transmit half of the SPI link to the MCU. This is a mode-0 SPI peripheral
//   clocked by the pixel clock. It oversamples sck/cs_n and shifts a buffered
//   word out on sdo, MSB first.
//
// Parameters
//   WIDTH      frame length in bits (>= 2)
//   IDLE_WORD  word sent when a frame starts with the holding buffer empty
//
// Ports
//   clk          pixel clock, rising edge
//   reset        asynchronous, active-low
//   sck, cs_n    SPI clock / chip select from the MCU (asynchronous)
//   tx_data      word to transmit
//   tx_valid     tx_data valid
//   tx_ready     holding buffer empty (word accepted on tx_valid && tx_ready)
//   sdo, sdo_en  serial data out and its pad output enable
//   frame_done   pulse: all WIDTH bits clocked
//   frame_abort  pulse: cs_n rose before WIDTH sck rises
//   underrun     pulse: frame started with the holding buffer empty
module spi_status_tx #(
  parameter int unsigned           WIDTH     = 16,
  parameter logic [WIDTH-1:0]      IDLE_WORD = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sck,
  input  logic             cs_n,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             sdo,
  output logic             sdo_en,
  output logic             frame_done,
  output logic             frame_abort,
  output logic             underrun
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Synchronizers plus one history flop each for edge detection
  logic r_sck_s1, r_sck_s2, r_sck_s3;
  logic r_cs_s1,  r_cs_s2,  r_cs_s3;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sck_s1 <= 1'b0;
      r_sck_s2 <= 1'b0;
      r_sck_s3 <= 1'b0;
      r_cs_s1  <= 1'b1;
      r_cs_s2  <= 1'b1;
      r_cs_s3  <= 1'b1;
    end else begin
      r_sck_s1 <= sck;
      r_sck_s2 <= r_sck_s1;
      r_sck_s3 <= r_sck_s2;
      r_cs_s1  <= cs_n;
      r_cs_s2  <= r_cs_s1;
      r_cs_s3  <= r_cs_s2;
    end
  end

  logic w_cs_fall, w_cs_rise, w_sck_rise, w_sck_fall;

  assign w_cs_fall  =  r_cs_s3 & ~r_cs_s2;
  assign w_cs_rise  = ~r_cs_s3 &  r_cs_s2;
  // sck activity counts only while the synchronized select is low
  assign w_sck_rise =  r_sck_s2 & ~r_sck_s3 & ~r_cs_s2;
  assign w_sck_fall = ~r_sck_s2 &  r_sck_s3 & ~r_cs_s2;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_buf;
  logic             r_full;

  // FSM control strobes
  logic w_load, w_consume, w_inc, w_shift;
  logic w_done, w_abort, w_under;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_consume   = 1'b0;
    w_inc       = 1'b0;
    w_shift     = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    w_under     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_cs_fall) begin
          w_load      = 1'b1;
          w_consume   = r_full;
          w_under     = ~r_full;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_cs_rise) begin
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_sck_rise) begin
          if (r_cnt < CW'(WIDTH)) w_inc = 1'b1;
          if ((r_cnt + CW'(1)) == CW'(WIDTH)) begin
            w_done      = 1'b1;
            w_state_nxt = DONE;
          end
        end else if (w_sck_fall && (r_cnt < CW'(WIDTH))) begin
          w_shift = 1'b1;
        end
      end
      DONE: begin
        if (w_cs_rise) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Shift register, bit counter and one-entry holding buffer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_buf   <= '0;
      r_full  <= 1'b0;
    end else begin
      if (w_load) begin
        r_shift <= r_full ? r_buf : IDLE_WORD;
        r_cnt   <= '0;
      end else begin
        if (w_shift) r_shift <= {r_shift[WIDTH-2:0], 1'b0};
        if (w_inc)   r_cnt   <= r_cnt + CW'(1);
      end
      // Acceptance needs empty and consumption needs full, so they never collide
      if (w_consume) begin
        r_full <= 1'b0;
      end else if (tx_valid && !r_full) begin
        r_full <= 1'b1;
        r_buf  <= tx_data;
      end
    end
  end

  // Pulses pass through one stage so every output lands 4 clk after its pin
  // edge, in step with sdo/sdo_en which are registered from the FSM state.
  logic r_done_p, r_abort_p, r_under_p;
  logic r_sdo, r_sdo_en, r_done, r_abort, r_under;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_done_p  <= 1'b0;
      r_abort_p <= 1'b0;
      r_under_p <= 1'b0;
      r_sdo     <= 1'b0;
      r_sdo_en  <= 1'b0;
      r_done    <= 1'b0;
      r_abort   <= 1'b0;
      r_under   <= 1'b0;
    end else begin
      r_done_p  <= w_done;
      r_abort_p <= w_abort;
      r_under_p <= w_under;
      r_sdo     <= (r_state == SHIFT) & r_shift[WIDTH-1];
      r_sdo_en  <= (r_state != IDLE);
      r_done    <= r_done_p;
      r_abort   <= r_abort_p;
      r_under   <= r_under_p;
    end
  end

  assign tx_ready    = ~r_full;
  assign sdo         = r_sdo;
  assign sdo_en      = r_sdo_en;
  assign frame_done  = r_done;
  assign frame_abort = r_abort;
  assign underrun    = r_under;

endmodule

// File: doc/spi_status_tx.md
# spi_status_tx

Transmit half of the FPGA-side SPI link to the MCU: a mode-0 SPI peripheral that shifts FPGA-generated words out on `sdo` while the MCU clocks a frame.
- Typical payloads are pixel readback, brush state, and acknowledgements.
- It runs entirely in the 25.175 MHz pixel-clock domain and oversamples `sck`/`cs_n`.
- Upstream logic loads words through a valid/ready handshake into a one-word holding buffer.
- It is the counterpart of the SPI receive/decode path that carries brush, color and coordinate packets into the design.

## Interface
- `WIDTH`, 16, frame length in bits, shifted MSB first; must be ≥2.
- `IDLE_WORD`, 16'h0000, word sent when a frame starts with the holding buffer empty (underrun).
- `clk` input 1: pixel clock; all logic is on its rising edge.
- `reset` input 1: asynchronous, active-low; asserted (0) clears all state.
- `sck` input 1: SPI clock from the MCU, asynchronous to `clk`; idles low (mode 0).
- `cs_n` input 1: SPI chip select, active-low, asynchronous to `clk`.
- `tx_data` input WIDTH: word to transmit.
- `tx_valid` input 1: `tx_data` is valid.
- `tx_ready` output 1: holding buffer is empty; a word is accepted when `tx_valid && tx_ready` at a `clk` edge.
- `sdo` output 1: serial data to the MCU.
- `sdo_en` output 1: output enable for the `sdo` pad driver; 1 only while selected.
- `frame_done` output 1: one-cycle pulse when all WIDTH bits of a frame have been clocked.
- `frame_abort` output 1: one-cycle pulse when `cs_n` rises before WIDTH rising `sck` edges.
- `underrun` output 1: one-cycle pulse when a frame starts with the holding buffer empty.

## Operation
- **Synchronizers:** `sck` and `cs_n` each pass through a 2-flop synchronizer plus a third history flop for edge detection.
  - Detected events: `cs_fall`, `cs_rise`, `sck_rise`, `sck_fall`.
  - `sck` edges are ignored while synchronized `cs_n` = 1.
- **State machine:** IDLE, SHIFT, DONE.
  - **IDLE** on `cs_fall`:
    - Load the shift register from the holding buffer if it is full, and mark the buffer empty.
    - Otherwise load `IDLE_WORD` and pulse `underrun`.
    - Bit counter ← 0; go to SHIFT.
  - **SHIFT:**
    - `sdo` = shift register MSB.
    - On `sck_rise`: counter += 1. The MCU samples on this edge, so no shift happens here.
    - On `sck_fall` with counter < WIDTH: shift left by one, filling with 0.
    - On the `sck_rise` that makes counter = WIDTH: pulse `frame_done`, go to DONE.
    - On `cs_rise`: pulse `frame_abort`, go to IDLE. The word is discarded, not retransmitted.
  - **DONE:**
    - `sdo` = 0; extra `sck` edges are ignored.
    - On `cs_rise`: go to IDLE with no pulse.
- **Enables:** `sdo_en` = 1 in SHIFT and DONE, 0 in IDLE. `sdo` = 0 whenever `sdo_en` = 0.
- **Holding buffer:** one entry.
  - `tx_ready` = !full.
  - Consumption happens only at `cs_fall` in IDLE.
  - Accepting a word and consuming the buffer in the same cycle is impossible: acceptance requires empty, consumption requires full.
  - If the buffer is empty at `cs_fall` and `tx_valid` is high that same cycle, the word is accepted into the buffer for the next frame. The current frame sends `IDLE_WORD` and pulses `underrun`.
  - If the buffer is full at `cs_fall`, it empties and `tx_ready` rises the next cycle.
- **Bit counter:** width $clog2(WIDTH+1); it never wraps, saturating at WIDTH.
- **Reset mid-frame:** immediate return to IDLE; buffer emptied; all outputs take their reset values; no pulses.

## Timing
- Reset values: `sdo` 0, `sdo_en` 0, `tx_ready` 1, `frame_done` 0, `frame_abort` 0, `underrun` 0.
- All outputs are registered.
- `sck` high and low times must each be ≥ 4 `clk` periods, i.e. `sck` ≤ ~3.1 MHz.
- `cs_n` high time between frames must be ≥ 4 `clk` periods.
- Latency from raw pin edge to detected event: 3 `clk` cycles.
- `cs_n` falling pin edge → first bit on `sdo` and `sdo_en` = 1: 4 `clk` cycles. The MCU must wait ≥ 4 `clk` before the first `sck` rise.
- `sck` falling pin edge → next bit on `sdo`: 4 `clk` cycles, which lies within the `sck` low phase.
- `frame_done` and `frame_abort` are asserted 4 `clk` after the respective `sck`/`cs_n` pin edge.
- `underrun` is asserted 4 `clk` after the `cs_n` pin edge.
- `tx_ready` falls in the cycle after acceptance.

## Test plan
- **Normal frame:**
  - Stimulus: after reset, load 16'hA5C3, then run a 16-clock frame at `sck` = clk/8.
  - Required: MCU samples 1010_0101_1100_0011; `frame_done` pulses once; `tx_ready` returns to 1 within 5 `clk` of `cs_n` fall.
- **Underrun:**
  - Stimulus: run a frame with the buffer empty and `IDLE_WORD` = 16'h0000.
  - Required: received 16'h0000; one `underrun` pulse; no `frame_abort`.
- **Abort:**
  - Stimulus: load 16'hFFFF; raise `cs_n` after 7 `sck` rises.
  - Required: 7 ones received; one `frame_abort` pulse, no `frame_done`; next frame with empty buffer yields `IDLE_WORD` plus `underrun`.
- **Back-to-back with simultaneous load:**
  - Stimulus: buffer empty; assert `tx_valid` with 16'h1234 in the exact `cs_fall` cycle.
  - Required: frame 1 sends `IDLE_WORD`; frame 2 sends 16'h1234.
- **Over-clocking and enable:**
  - Stimulus: issue 20 `sck` pulses in one frame.
  - Required: bits 17–20 read 0; exactly one `frame_done`; `sdo_en` is 0 before `cs_n` fall and after `cs_n` rise.
- **Async reset mid-frame:**
  - Stimulus: assert `reset` = 0 after 5 bits.
  - Required: all outputs at reset values within the same cycle; `tx_ready` = 1; after release, a new frame with 16'h00FF is received intact.
